// File: rtl/goal_referee.sv
// Match referee: debounced goal detection, scoring, celebration freeze and kickoff pulse.
// Optional match timer is built when GOAL_REFEREE_TIMER_EN is defined.
module goal_referee #(
  parameter int unsigned LEFT_LINE      = 10,
  parameter int unsigned RIGHT_LINE     = 629,
  parameter int unsigned WRAP_X         = 900,
  parameter int unsigned GOAL_Y_TOP     = 176,
  parameter int unsigned GOAL_Y_BOTTOM  = 316,
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned PAUSE_FRAMES   = 120,
  parameter int unsigned WIN_SCORE      = 5,
  parameter int unsigned MATCH_SECONDS  = 90,
  parameter int unsigned FPS            = 60
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic       restart,
  output logic       goal_reset,
  output logic       celebrate,
  output logic [3:0] ScoreL,
  output logic [3:0] ScoreR,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [6:0] TimeLeft
);

  if (CONFIRM_FRAMES == 0 || CONFIRM_FRAMES > 7 || PAUSE_FRAMES == 0 || PAUSE_FRAMES > 255 ||
      WIN_SCORE == 0 || WIN_SCORE > 15 || MATCH_SECONDS == 0 || MATCH_SECONDS > 127 ||
      FPS == 0 || FPS > 256) begin : g_bad_cfg
    $error("goal_referee: parameter out of range");
  end

  localparam logic [9:0] LeftLine      = 10'(LEFT_LINE);
  localparam logic [9:0] RightLine     = 10'(RIGHT_LINE);
  localparam logic [9:0] WrapX         = 10'(WRAP_X);
  localparam logic [9:0] YTop          = 10'(GOAL_Y_TOP);
  localparam logic [9:0] YBot          = 10'(GOAL_Y_BOTTOM);
  localparam logic [2:0] ConfirmFrames = 3'(CONFIRM_FRAMES);
  localparam logic [7:0] PauseLast     = 8'(PAUSE_FRAMES - 1);
  localparam logic [3:0] WinScore      = 4'(WIN_SCORE);
`ifdef GOAL_REFEREE_TIMER_EN
  localparam logic [7:0] FpsLast       = 8'(FPS - 1);
  localparam logic [6:0] MatchSecs     = 7'(MATCH_SECONDS);
`endif

  typedef enum logic [1:0] {StPlay, StCelebrate, StKickoff, StGameOver} state_e;

  state_e     state_q, state_d;
  logic [2:0] confirm_q, confirm_d;
  logic       side_q, side_d;  // side being confirmed: 0 left goal, 1 right goal
  logic [7:0] pause_q, pause_d;
  logic       goal_reset_q, goal_reset_d;
  logic       celebrate_q, celebrate_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
`ifdef GOAL_REFEREE_TIMER_EN
  logic [7:0] frame_q, frame_d;
  logic [6:0] time_left_q, time_left_d;
`endif

  logic       in_mouth, in_left, in_right;
  logic [2:0] confirm_inc;
  logic       goal_hit;
  logic       timer_zero;
  logic       match_over;

  function automatic logic [1:0] win_code(input logic [3:0] l, input logic [3:0] r);
    if (l > r)      return 2'b01;
    else if (r > l) return 2'b10;
    else            return 2'b11;
  endfunction

  always_comb begin
    in_mouth = (BallY >= YTop) && (BallY <= YBot);
    in_left  = in_mouth && ((BallX <= LeftLine) || (BallX >= WrapX));
    in_right = in_mouth && (BallX >= RightLine) && (BallX < WrapX);
`ifdef GOAL_REFEREE_TIMER_EN
    timer_zero = (time_left_q == '0);
`else
    timer_zero = 1'b0;
`endif
    match_over = (score_l_q >= WinScore) || (score_r_q >= WinScore) || timer_zero;
  end

  always_comb begin
    state_d      = state_q;
    confirm_d    = confirm_q;
    side_d       = side_q;
    pause_d      = pause_q;
    goal_reset_d = 1'b0;
    celebrate_d  = celebrate_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    confirm_inc  = '0;
    goal_hit     = 1'b0;
`ifdef GOAL_REFEREE_TIMER_EN
    frame_d      = frame_q;
    time_left_d  = time_left_q;
`endif

    unique case (state_q)
      StPlay: begin
        if (in_left || in_right) begin
          // A side change restarts the debounce with this frame as the first sample.
          if (confirm_q != '0 && side_q != in_right) confirm_inc = 3'd1;
          else                                       confirm_inc = confirm_q + 3'd1;
          side_d = in_right;
          if (confirm_inc >= ConfirmFrames) begin
            goal_hit    = 1'b1;
            state_d     = StCelebrate;
            celebrate_d = 1'b1;
            confirm_d   = '0;
            pause_d     = '0;
            if (in_left) begin
              if (score_r_q != 4'hF) score_r_d = score_r_q + 4'd1;
            end else begin
              if (score_l_q != 4'hF) score_l_d = score_l_q + 4'd1;
            end
          end else begin
            confirm_d = confirm_inc;
          end
        end else begin
          confirm_d = '0;
        end
`ifdef GOAL_REFEREE_TIMER_EN
        if (frame_q == FpsLast) begin
          frame_d = '0;
          if (time_left_q != '0) time_left_d = time_left_q - 7'd1;
        end else begin
          frame_d = frame_q + 8'd1;
        end
        // A goal on the expiry edge takes priority; the match then ends after kickoff.
        if (!goal_hit && time_left_d == '0) begin
          state_d     = StGameOver;
          game_over_d = 1'b1;
          winner_d    = win_code(score_l_q, score_r_q);
          confirm_d   = '0;
        end
`endif
      end

      StCelebrate: begin
        if (pause_q == PauseLast) begin
          state_d      = StKickoff;
          goal_reset_d = 1'b1;
          pause_d      = '0;
        end else begin
          pause_d = pause_q + 8'd1;
        end
      end

      StKickoff: begin
        celebrate_d = 1'b0;
        if (match_over) begin
          state_d     = StGameOver;
          game_over_d = 1'b1;
          winner_d    = win_code(score_l_q, score_r_q);
        end else begin
          state_d = StPlay;
        end
      end

      StGameOver: begin
        if (restart) begin
          state_d      = StKickoff;
          goal_reset_d = 1'b1;
          score_l_d    = '0;
          score_r_d    = '0;
          game_over_d  = 1'b0;
          winner_d     = 2'b00;
`ifdef GOAL_REFEREE_TIMER_EN
          time_left_d  = MatchSecs;
          frame_d      = '0;
`endif
        end
      end

      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= StPlay;
      confirm_q    <= '0;
      side_q       <= 1'b0;
      pause_q      <= '0;
      goal_reset_q <= 1'b0;
      celebrate_q  <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
`ifdef GOAL_REFEREE_TIMER_EN
      frame_q      <= '0;
      time_left_q  <= MatchSecs;
`endif
    end else begin
      state_q      <= state_d;
      confirm_q    <= confirm_d;
      side_q       <= side_d;
      pause_q      <= pause_d;
      goal_reset_q <= goal_reset_d;
      celebrate_q  <= celebrate_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
`ifdef GOAL_REFEREE_TIMER_EN
      frame_q      <= frame_d;
      time_left_q  <= time_left_d;
`endif
    end
  end

  assign goal_reset = goal_reset_q;
  assign celebrate  = celebrate_q;
  assign ScoreL     = score_l_q;
  assign ScoreR     = score_r_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
`ifdef GOAL_REFEREE_TIMER_EN
  assign TimeLeft   = time_left_q;
`else
  assign TimeLeft   = '0;
`endif

endmodule

// File: tb/tb_goal_referee.sv
// Directed self-checking bench for goal_referee; the timer scenario runs when
// GOAL_REFEREE_TIMER_EN is defined, the default-build scenarios otherwise.
module tb_goal_referee;

  localparam int PauseFrames = 120;
`ifdef GOAL_REFEREE_TIMER_EN
  localparam int ExpTimeReset = 2;
`else
  localparam int ExpTimeReset = 0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic       restart;
  logic       goal_reset;
  logic       celebrate;
  logic [3:0] ScoreL;
  logic [3:0] ScoreR;
  logic       game_over;
  logic [1:0] winner;
  logic [6:0] TimeLeft;

  int n_cmp = 0;
  int n_err = 0;
  int exp_l = 0;
  int exp_r = 0;

  goal_referee #(
    .MATCH_SECONDS(2)
  ) u_dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .BallX      (BallX),
    .BallY      (BallY),
    .restart    (restart),
    .goal_reset (goal_reset),
    .celebrate  (celebrate),
    .ScoreL     (ScoreL),
    .ScoreR     (ScoreR),
    .game_over  (game_over),
    .winner     (winner),
    .TimeLeft   (TimeLeft)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic ball(input int x, input int y);
    BallX = 10'(x);
    BallY = 10'(y);
  endtask

  // Call right after the edge where celebrate rose.
  task automatic finish_freeze(input string tag);
    int pulses = 0;
    int drops  = 0;
    for (int i = 0; i < PauseFrames - 1; i++) begin
      tick();
      if (goal_reset) pulses++;
      if (!celebrate) drops++;
    end
    check_eq({tag, " early goal_reset"}, pulses, 0);
    check_eq({tag, " celebrate held"}, drops, 0);
    tick();
    check_eq({tag, " goal_reset pulse"}, goal_reset, 1);
    check_eq({tag, " celebrate in kickoff"}, celebrate, 1);
    tick();
    check_eq({tag, " goal_reset fall"}, goal_reset, 0);
    check_eq({tag, " celebrate fall"}, celebrate, 0);
  endtask

  task automatic score_goal(input string tag, input int x, input int y, input bit left_goal);
    ball(x, y);
    tick();
    check_eq({tag, " no goal after 1 frame"}, celebrate, 0);
    tick();
    if (left_goal) exp_r++;
    else           exp_l++;
    check_eq({tag, " celebrate"}, celebrate, 1);
    check_eq({tag, " ScoreL"}, ScoreL, exp_l);
    check_eq({tag, " ScoreR"}, ScoreR, exp_r);
    ball(320, 240);
    finish_freeze(tag);
  endtask

  task automatic idle_frames(input string tag, input int n);
    int cel = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (celebrate) cel++;
    end
    check_eq({tag, " no celebrate"}, cel, 0);
    check_eq({tag, " ScoreL"}, ScoreL, exp_l);
    check_eq({tag, " ScoreR"}, ScoreR, exp_r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    restart = 1'b0;
    ball(320, 240);
    tick();
    tick();
    check_eq("reset goal_reset", goal_reset, 0);
    check_eq("reset celebrate", celebrate, 0);
    check_eq("reset ScoreL", ScoreL, 0);
    check_eq("reset ScoreR", ScoreR, 0);
    check_eq("reset game_over", game_over, 0);
    check_eq("reset winner", winner, 0);
    check_eq("reset TimeLeft", TimeLeft, ExpTimeReset);
    Reset_n = 1'b1;

`ifdef GOAL_REFEREE_TIMER_EN
    // Expiry with no goals: 2 -> 1 at PLAY edge 60, -> 0 and GAME_OVER at edge 120.
    for (int i = 0; i < 59; i++) tick();
    check_eq("timer edge59", TimeLeft, 2);
    tick();
    check_eq("timer edge60", TimeLeft, 1);
    for (int i = 0; i < 59; i++) tick();
    check_eq("timer edge119", TimeLeft, 1);
    check_eq("timer edge119 game_over", game_over, 0);
    tick();
    check_eq("timer edge120", TimeLeft, 0);
    check_eq("timer expiry game_over", game_over, 1);
    check_eq("timer expiry winner draw", winner, 3);
    check_eq("timer expiry no goal_reset", goal_reset, 0);
    tick();
    check_eq("timer over holds", game_over, 1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("timer restart reload", TimeLeft, 2);
    check_eq("timer restart goal_reset", goal_reset, 1);
    check_eq("timer restart game_over", game_over, 0);
    tick();
    // Goal confirming on the expiry edge is scored; the match ends after kickoff.
    for (int i = 0; i < 118; i++) tick();
    ball(680, 250);
    tick();
    check_eq("timer goal edge119 celebrate", celebrate, 0);
    check_eq("timer goal edge119 time", TimeLeft, 1);
    tick();
    exp_l = 1;
    check_eq("timer goal celebrate", celebrate, 1);
    check_eq("timer goal ScoreL", ScoreL, exp_l);
    check_eq("timer goal time zero", TimeLeft, 0);
    check_eq("timer goal not over yet", game_over, 0);
    ball(320, 240);
    finish_freeze("timer goal");
    check_eq("timer kickoff game_over", game_over, 1);
    check_eq("timer kickoff winner left", winner, 1);
`else
    score_goal("left goal", 5, 250, 1'b1);
    check_eq("left goal back to play", game_over, 0);

    // Single frame in the wrapped left goal must not confirm once the ball leaves.
    ball(974, 200);
    tick();
    ball(320, 200);
    tick();
    check_eq("wrap debounce no score", ScoreR, exp_r);
    score_goal("wrap left goal", 974, 200, 1'b1);

    ball(5, 100);
    idle_frames("above mouth", 10);
    ball(640, 317);
    idle_frames("below mouth", 5);
    ball(11, 250);
    idle_frames("past left line", 5);
    score_goal("left boundary", 10, 176, 1'b1);

    ball(320, 240);
    restart = 1'b1;
    tick();
    tick();
    restart = 1'b0;
    check_eq("restart ignored ScoreR", ScoreR, exp_r);
    check_eq("restart ignored goal_reset", goal_reset, 0);

    score_goal("right boundary", 629, 316, 1'b0);
    for (int g = 0; g < 4; g++) begin
      score_goal("right goal", 680, 250, 1'b0);
      check_eq("right goal game_over", game_over, (exp_l >= 5) ? 1 : 0);
    end
    check_eq("win winner left", winner, 1);

    ball(5, 250);
    for (int i = 0; i < 3; i++) tick();
    check_eq("over ScoreL frozen", ScoreL, 5);
    check_eq("over ScoreR frozen", ScoreR, 3);
    check_eq("over celebrate", celebrate, 0);
    check_eq("over winner held", winner, 1);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    ball(320, 240);
    exp_l = 0;
    exp_r = 0;
    check_eq("restart goal_reset", goal_reset, 1);
    check_eq("restart ScoreL", ScoreL, 0);
    check_eq("restart ScoreR", ScoreR, 0);
    check_eq("restart game_over", game_over, 0);
    check_eq("restart winner", winner, 0);
    tick();
    check_eq("restart pulse fall", goal_reset, 0);

    // Reset during the freeze: outputs clear immediately and no kickoff follows.
    ball(5, 250);
    tick();
    tick();
    check_eq("mid goal ScoreR", ScoreR, 1);
    check_eq("mid goal celebrate", celebrate, 1);
    ball(320, 240);
    for (int i = 0; i < 49; i++) tick();
    Reset_n = 1'b0;
    #1;
    check_eq("async reset celebrate", celebrate, 0);
    check_eq("async reset ScoreR", ScoreR, 0);
    check_eq("async reset goal_reset", goal_reset, 0);
    check_eq("async reset game_over", game_over, 0);
    tick();
    Reset_n = 1'b1;
    begin
      int pulses = 0;
      int cel = 0;
      for (int i = 0; i < 130; i++) begin
        tick();
        if (goal_reset) pulses++;
        if (celebrate) cel++;
      end
      check_eq("after reset no goal_reset", pulses, 0);
      check_eq("after reset no celebrate", cel, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
